// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and helpers for the reg_bank_mux slice.
// Holds the select-width derivation, the parameter limits and the
// reserved "zero" select code helper used by the top.
// Configuration macro: REG_BANK_BYPASS_EN (used by reg_bank_mux only).

package reg_bank_pkg;

    // Legal parameter ranges for the bank
    localparam int MIN_NUM_CH = 2;
    localparam int MAX_NUM_CH = 16;
    localparam int MIN_DWELL  = 1;
    localparam int MAX_DWELL  = 256;

    // Select width must be able to encode every channel plus the zero code
    function automatic int sel_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

    // The first code past the last channel is reserved as "output zero"
    function automatic int zero_code(input int num_ch);
        return num_ch;
    endfunction

    // Dwell counter width; a dwell of one still needs a one-bit counter
    function automatic int dwell_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage : reg_bank_pkg

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one DATA_W-bit storage register with a load enable.
// Captures d on a rising edge when ld is high, otherwise holds.
// Configuration macro: REG_BANK_BYPASS_EN (no effect on this cell).

module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] store_d;
    logic [DATA_W-1:0] store_q;

    // Next stored value: new data when loading, else keep the old value
    always_comb begin
        store_d = store_q;
        if (ld) begin
            store_d = d;
        end
    end

    // Storage flop, cleared asynchronously by reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            store_q <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    assign q = store_q;

endmodule : reg_bank_cell

// File: rtl/reg_bank_mux.sv
// reg_bank_mux: NUM_CH load-enabled channel registers with a registered
// output selector. The selection comes from output_sel or, when scan_en is
// high, from an internal sequencer that holds each channel for DWELL cycles.
// Selecting the reserved zero code (NUM_CH) outputs zero with out_valid low.
// Configuration macro: REG_BANK_BYPASS_EN - when defined, a channel being
// loaded on the same edge it is selected is written through to data_out.

module reg_bank_mux
    import reg_bank_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 16,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_CH*DATA_W-1:0] Data_in,
    input  logic [NUM_CH-1:0]        ld,
    input  logic [SEL_W-1:0]         output_sel,
    input  logic                     scan_en,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid
);

    localparam int                   DWELL_W    = dwell_width(DWELL);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]     LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0]     ZERO_CODE  = SEL_W'(zero_code(NUM_CH));

    // Channel storage outputs
    logic [DATA_W-1:0] ch_q [NUM_CH];

    // Scan sequencer state
    logic [SEL_W-1:0]   scan_ptr_d;
    logic [SEL_W-1:0]   scan_ptr_q;
    logic [DWELL_W-1:0] dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q;

    // Output stage
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W-1:0] data_out_q;
    logic [SEL_W-1:0]  out_ch_d;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_d;
    logic              out_valid_q;

    // Selection datapath
    logic [SEL_W-1:0]  eff_sel;
    logic              sel_in_range;
    logic [DATA_W-1:0] sel_data;

    // One storage cell per channel, each loading its own Data_in slice
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
        reg_bank_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .Clock (Clock),
            .Reset (Reset),
            .ld    (ld[g]),
            .d     (Data_in[g*DATA_W +: DATA_W]),
            .q     (ch_q[g])
        );
    end

    // Effective select: the sequencer owns selection while scanning
    always_comb begin
        eff_sel      = scan_en ? scan_ptr_q : output_sel;
        sel_in_range = (eff_sel < ZERO_CODE);
    end

`ifdef REG_BANK_BYPASS_EN
    // Channel mux with write-through: a channel loading this edge shows new data
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                if (ld[k]) begin
                    sel_data = Data_in[k*DATA_W +: DATA_W];
                end else begin
                    sel_data = ch_q[k];
                end
            end
        end
    end
`else
    // Channel mux reading stored values only; a same-edge load shows next cycle
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_data = ch_q[k];
            end
        end
    end
`endif

    // Sequencer next state: count dwell, advance and wrap pointer, freeze when idle
    always_comb begin
        scan_ptr_d  = scan_ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        if (scan_en) begin
            if (dwell_cnt_q == DWELL_LAST) begin
                dwell_cnt_d = '0;
                if (scan_ptr_q == LAST_CH) begin
                    scan_ptr_d = '0;
                end else begin
                    scan_ptr_d = scan_ptr_q + SEL_W'(1);
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
        end
    end

    // Output next state: out-of-range codes present zero and flag invalid
    always_comb begin
        data_out_d  = sel_in_range ? sel_data : '0;
        out_ch_d    = eff_sel;
        out_valid_d = sel_in_range;
    end

    // Sequencer and output registers; reset restarts scanning at channel 0
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            scan_ptr_q  <= '0;
            dwell_cnt_q <= '0;
            data_out_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            scan_ptr_q  <= scan_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            data_out_q  <= data_out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule : reg_bank_mux

// File: tb/tb_reg_bank_mux.sv
// tb_reg_bank_mux: directed test of reg_bank_mux with NUM_CH=3, DATA_W=16,
// DWELL=2. Expected values are hand-computed constants.

module tb_reg_bank_mux;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;
    localparam int DWELL  = 2;
    localparam int SEL_W  = 2;

    logic                     Clock;
    logic                     Reset;
    logic [NUM_CH*DATA_W-1:0] Data_in;
    logic [NUM_CH-1:0]        ld;
    logic [SEL_W-1:0]         output_sel;
    logic                     scan_en;
    logic [DATA_W-1:0]        data_out;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;

    int checkCount;
    int errorCount;

    reg_bank_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DWELL  (DWELL)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Data_in    (Data_in),
        .ld         (ld),
        .output_sel (output_sel),
        .scan_en    (scan_en),
        .data_out   (data_out),
        .out_ch     (out_ch),
        .out_valid  (out_valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check the full output triple
    task automatic checkAll(input string tag, input logic [15:0] expData,
                            input logic [1:0] expCh, input logic expValid);
        checkOutput({tag, ".data"}, 32'(data_out), 32'(expData));
        checkOutput({tag, ".ch"}, 32'(out_ch), 32'(expCh));
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'(expValid));
    endtask

    // Drive inputs, then advance past one rising edge
    task automatic applyStimulus(input logic [47:0] data, input logic [2:0] ldv,
                                 input logic [1:0] sel, input logic scan);
        Data_in    = data;
        ld         = ldv;
        output_sel = sel;
        scan_en    = scan;
        @(posedge Clock);
        #1;
    endtask

    logic [47:0] bankA;
    logic [47:0] bankB;
    logic [47:0] bankC;

    initial begin
        checkCount = 0;
        errorCount = 0;
        bankA = {16'h00FF, 16'hABCD, 16'h1234};
        bankB = {16'h00FF, 16'hABCD, 16'h5555};
        bankC = {16'hC333, 16'hB222, 16'hA111};

        Reset      = 1'b1;
        Data_in    = '0;
        ld         = '0;
        output_sel = '0;
        scan_en    = 1'b0;
        #3;
        checkAll("reset", 16'h0000, 2'd0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Load all three channels, then select channel 1
        applyStimulus(bankA, 3'b111, 2'd0, 1'b0);
        applyStimulus(bankA, 3'b000, 2'd1, 1'b0);
        checkAll("sel1", 16'hABCD, 2'd1, 1'b1);

        // Zero code, then back in range
        applyStimulus(bankA, 3'b000, 2'd3, 1'b0);
        checkAll("zero", 16'h0000, 2'd3, 1'b0);
        applyStimulus(bankA, 3'b000, 2'd2, 1'b0);
        checkAll("sel2", 16'h00FF, 2'd2, 1'b1);
        applyStimulus(bankA, 3'b000, 2'd0, 1'b0);
        checkAll("sel0", 16'h1234, 2'd0, 1'b1);

        // Load the channel being read on the same edge
        applyStimulus(bankB, 3'b001, 2'd0, 1'b0);
`ifdef REG_BANK_BYPASS_EN
        checkAll("sameEdge", 16'h5555, 2'd0, 1'b1);
`else
        checkAll("sameEdge", 16'h1234, 2'd0, 1'b1);
`endif
        applyStimulus(bankB, 3'b000, 2'd0, 1'b0);
        checkAll("afterLoad", 16'h5555, 2'd0, 1'b1);

        // Scan with DWELL=2; output_sel is ignored while scanning
        applyStimulus(bankB, 3'b000, 2'd3, 1'b1);
        checkAll("scan0a", 16'h5555, 2'd0, 1'b1);
        applyStimulus(bankB, 3'b000, 2'd3, 1'b1);
        checkAll("scan0b", 16'h5555, 2'd0, 1'b1);
        applyStimulus(bankB, 3'b000, 2'd3, 1'b1);
        checkAll("scan1a", 16'hABCD, 2'd1, 1'b1);

        // Pause scanning for three cycles under external select
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bankB, 3'b000, 2'd2, 1'b0);
            checkAll($sformatf("pause%0d", i), 16'h00FF, 2'd2, 1'b1);
        end

        // Resume: one more channel 1 cycle, then channel 2
        applyStimulus(bankB, 3'b000, 2'd0, 1'b1);
        checkAll("resume1", 16'hABCD, 2'd1, 1'b1);
        applyStimulus(bankB, 3'b000, 2'd0, 1'b1);
        checkAll("resume2", 16'h00FF, 2'd2, 1'b1);

        // Asynchronous reset mid-scan, away from the clock edge
        #2;
        Reset = 1'b1;
        #1;
        checkAll("asyncReset", 16'h0000, 2'd0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Scan restarts at channel 0 with a full dwell; channels were cleared
        applyStimulus(bankB, 3'b000, 2'd2, 1'b1);
        checkAll("restart0a", 16'h0000, 2'd0, 1'b1);
        applyStimulus(bankB, 3'b000, 2'd2, 1'b1);
        checkAll("restart0b", 16'h0000, 2'd0, 1'b1);
        applyStimulus(bankB, 3'b000, 2'd2, 1'b1);
        checkAll("restart1", 16'h0000, 2'd1, 1'b1);

        // Load every channel at once, then sweep the select
        applyStimulus(bankC, 3'b111, 2'd0, 1'b0);
        applyStimulus(bankC, 3'b000, 2'd0, 1'b0);
        checkAll("sweep0", 16'hA111, 2'd0, 1'b1);
        applyStimulus(bankC, 3'b000, 2'd1, 1'b0);
        checkAll("sweep1", 16'hB222, 2'd1, 1'b1);
        applyStimulus(bankC, 3'b000, 2'd2, 1'b0);
        checkAll("sweep2", 16'hC333, 2'd2, 1'b1);
        applyStimulus(bankC, 3'b000, 2'd3, 1'b0);
        checkAll("sweep3", 16'h0000, 2'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_reg_bank_mux
